// File: rtl/qarctan_channel_arbiter_if.sv
// Handshake bundle between the channel arbiter and its surrounding FIFOs:
// two channel input pairs (Y/X), the shared core's input and result FIFOs,
// and the two channel output FIFOs.
interface qarctan_channel_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ch0_y_rd_en,  ch1_y_rd_en;
  logic                  ch0_y_empty,  ch1_y_empty;
  logic [DATA_WIDTH-1:0] ch0_y_dout,   ch1_y_dout;
  logic                  ch0_x_rd_en,  ch1_x_rd_en;
  logic                  ch0_x_empty,  ch1_x_empty;
  logic [DATA_WIDTH-1:0] ch0_x_dout,   ch1_x_dout;

  logic                  core_y_wr_en, core_x_wr_en;
  logic                  core_y_full,  core_x_full;
  logic [DATA_WIDTH-1:0] core_y_din,   core_x_din;

  logic                  core_out_rd_en;
  logic                  core_out_empty;
  logic [DATA_WIDTH-1:0] core_out_dout;

  logic                  ch0_out_wr_en, ch1_out_wr_en;
  logic                  ch0_out_full,  ch1_out_full;
  logic [DATA_WIDTH-1:0] ch0_out_din,   ch1_out_din;

  // Arbiter side
  modport master (
    output ch0_y_rd_en, ch1_y_rd_en, ch0_x_rd_en, ch1_x_rd_en,
    input  ch0_y_empty, ch1_y_empty, ch0_x_empty, ch1_x_empty,
    input  ch0_y_dout,  ch1_y_dout,  ch0_x_dout,  ch1_x_dout,
    output core_y_wr_en, core_x_wr_en, core_y_din, core_x_din,
    input  core_y_full,  core_x_full,
    output core_out_rd_en,
    input  core_out_empty, core_out_dout,
    output ch0_out_wr_en, ch1_out_wr_en, ch0_out_din, ch1_out_din,
    input  ch0_out_full,  ch1_out_full
  );

  // FIFO / environment side
  modport slave (
    input  ch0_y_rd_en, ch1_y_rd_en, ch0_x_rd_en, ch1_x_rd_en,
    output ch0_y_empty, ch1_y_empty, ch0_x_empty, ch1_x_empty,
    output ch0_y_dout,  ch1_y_dout,  ch0_x_dout,  ch1_x_dout,
    input  core_y_wr_en, core_x_wr_en, core_y_din, core_x_din,
    output core_y_full,  core_x_full,
    input  core_out_rd_en,
    output core_out_empty, core_out_dout,
    input  ch0_out_wr_en, ch1_out_wr_en, ch0_out_din, ch1_out_din,
    output ch0_out_full,  ch1_out_full
  );
endinterface

// File: rtl/qarctan_channel_arbiter.sv
// Round-robin sharing of one qarctan core between two channels. Each issued
// Y/X pair leaves a one-bit channel tag in an in-order queue; core results
// are steered back to the channel named by the tag at the queue head.
module qarctan_channel_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  qarctan_channel_arbiter_if.master bus,
  output logic [CNT_WIDTH-1:0] outstanding,
  output logic                 busy
);

  localparam int                   PTR_W   = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       last_grant_q;

  logic                  core_ok, elig0, elig1, grant0, grant1, issue;
  logic                  head_tag, head_full, retire;
  logic [DATA_WIDTH-1:0] y_sel, x_sel;

  // Eligibility, round-robin grant and head-of-line retire decision
  always_comb begin
    core_ok   = !reset && !bus.core_y_full && !bus.core_x_full && (cnt_q != CNT_MAX);
    elig0     = core_ok && !bus.ch0_y_empty && !bus.ch0_x_empty;
    elig1     = core_ok && !bus.ch1_y_empty && !bus.ch1_x_empty;
    // On a tie the channel that did not win last time goes next
    grant0    = elig0 && (!elig1 || last_grant_q);
    grant1    = elig1 && (!elig0 || !last_grant_q);
    issue     = grant0 || grant1;
    y_sel     = grant1 ? bus.ch1_y_dout : bus.ch0_y_dout;
    x_sel     = grant1 ? bus.ch1_x_dout : bus.ch0_x_dout;
    head_tag  = tag_q[rd_ptr_q];
    // Results never bypass each other: a full head channel stalls everything
    head_full = head_tag ? bus.ch1_out_full : bus.ch0_out_full;
    retire    = !reset && !bus.core_out_empty && (cnt_q != '0) && !head_full;
  end

  assign bus.ch0_y_rd_en    = grant0;
  assign bus.ch0_x_rd_en    = grant0;
  assign bus.ch1_y_rd_en    = grant1;
  assign bus.ch1_x_rd_en    = grant1;
  assign bus.core_y_wr_en   = issue;
  assign bus.core_x_wr_en   = issue;
  assign bus.core_y_din     = y_sel;
  assign bus.core_x_din     = x_sel;
  assign bus.core_out_rd_en = retire;
  assign bus.ch0_out_wr_en  = retire && !head_tag;
  assign bus.ch1_out_wr_en  = retire && head_tag;
  assign bus.ch0_out_din    = bus.core_out_dout;
  assign bus.ch1_out_din    = bus.core_out_dout;
  assign outstanding        = cnt_q;
  assign busy               = (cnt_q != '0);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = issue  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({issue, retire})
      2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
      2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag queue and arbitration state
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (issue) begin
        tag_q[wr_ptr_q] <= grant1;
        last_grant_q    <= grant1;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // A core result with no tag to route it means the core and arbiter lost sync
  a_no_orphan_result : assert property (@(posedge clock) disable iff (reset)
    !(!bus.core_out_empty && cnt_q == '0))
    else $error("core result present with empty tag queue");

endmodule

// File: tb/tb_qarctan_channel_arbiter.sv
module tb_qarctan_channel_arbiter;
  localparam int DW = 32;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] outstanding;
  logic       busy;

  qarctan_channel_arbiter_if #(.DATA_WIDTH(DW)) ifc ();

  qarctan_channel_arbiter #(
    .DATA_WIDTH(DW), .MAX_OUTSTANDING(16), .CNT_WIDTH(5)
  ) dut (
    .clock(clock), .reset(reset), .bus(ifc),
    .outstanding(outstanding), .busy(busy)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic e0y, e0x, e1y, e1x, cfull, coe, o0f, o1f;
    logic [4:0] cnt;
    logic rd0, rd1, crd, o0wr, o1wr;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic avail(input logic a0, input logic a1);
    ifc.ch0_y_empty = !a0; ifc.ch0_x_empty = !a0;
    ifc.ch1_y_empty = !a1; ifc.ch1_x_empty = !a1;
  endtask

  task automatic idle();
    avail(1'b0, 1'b0);
    ifc.core_y_full = 0; ifc.core_x_full = 0;
    ifc.core_out_empty = 1; ifc.core_out_dout = 32'hC0DE_0000;
    ifc.ch0_out_full = 0; ifc.ch1_out_full = 0;
    ifc.ch0_y_dout = 32'h1000; ifc.ch0_x_dout = 32'h1100;
    ifc.ch1_y_dout = 32'h2000; ifc.ch1_x_dout = 32'h2100;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    reset = 1'b0;
  endtask

  // Retire everything outstanding, counting writes per channel
  task automatic drain(input string name, output int n0, output int n1);
    n0 = 0; n1 = 0;
    avail(1'b0, 1'b0);
    ifc.ch0_out_full = 0; ifc.ch1_out_full = 0;
    for (int k = 0; k < 40; k++) begin
      if (outstanding == 0) break;
      ifc.core_out_empty = 0;
      #2;
      if (ifc.ch0_out_wr_en) n0++;
      if (ifc.ch1_out_wr_en) n1++;
      tick();
    end
    ifc.core_out_empty = 1;
    chk({name, "_drained"}, outstanding, 0);
  endtask

  initial begin
    int n0, n1, cnt, bad;
    reset = 1'b1;
    idle();

    //            e0y e0x e1y e1x cf coe o0f o1f  cnt  rd0 rd1 crd o0w o1w
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd1, 1'b0,1'b1,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd2, 1'b1,1'b0,1'b1,1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1, 5'd2, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd2, 1'b0,1'b0,1'b1,1'b0,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd1, 1'b0,1'b1,1'b1,1'b1,1'b0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 5'd1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'd1, 1'b1,1'b0,1'b1,1'b0,1'b1};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0, 5'd1, 1'b0,1'b0,1'b0,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 5'd1, 1'b0,1'b0,1'b1,1'b1,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0, 5'd0, 1'b0,1'b0,1'b0,1'b0,1'b0};

    tick(); tick();
    chk("reset_outstanding", outstanding, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;

    // Table-driven cycle-by-cycle vectors
    for (int i = 0; i < 11; i++) begin
      ifc.ch0_y_empty = vecs[i].e0y; ifc.ch0_x_empty = vecs[i].e0x;
      ifc.ch1_y_empty = vecs[i].e1y; ifc.ch1_x_empty = vecs[i].e1x;
      ifc.core_y_full = vecs[i].cfull; ifc.core_x_full = vecs[i].cfull;
      ifc.core_out_empty = vecs[i].coe;
      ifc.ch0_out_full = vecs[i].o0f; ifc.ch1_out_full = vecs[i].o1f;
      ifc.ch0_y_dout = 32'h1000 + i; ifc.ch0_x_dout = 32'h1100 + i;
      ifc.ch1_y_dout = 32'h2000 + i; ifc.ch1_x_dout = 32'h2100 + i;
      ifc.core_out_dout = 32'hC000 + i;
      #2;
      chk($sformatf("v%0d_cnt", i), outstanding, vecs[i].cnt);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].cnt != 0);
      chk($sformatf("v%0d_ch0_rd", i), {ifc.ch0_y_rd_en, ifc.ch0_x_rd_en}, {2{vecs[i].rd0}});
      chk($sformatf("v%0d_ch1_rd", i), {ifc.ch1_y_rd_en, ifc.ch1_x_rd_en}, {2{vecs[i].rd1}});
      chk($sformatf("v%0d_core_wr", i), {ifc.core_y_wr_en, ifc.core_x_wr_en},
          {2{vecs[i].rd0 | vecs[i].rd1}});
      chk($sformatf("v%0d_core_rd", i), ifc.core_out_rd_en, vecs[i].crd);
      chk($sformatf("v%0d_out0_wr", i), ifc.ch0_out_wr_en, vecs[i].o0wr);
      chk($sformatf("v%0d_out1_wr", i), ifc.ch1_out_wr_en, vecs[i].o1wr);
      if (vecs[i].rd0 || vecs[i].rd1) begin
        chk($sformatf("v%0d_core_y_din", i), ifc.core_y_din,
            vecs[i].rd1 ? 32'h2000 + i : 32'h1000 + i);
        chk($sformatf("v%0d_core_x_din", i), ifc.core_x_din,
            vecs[i].rd1 ? 32'h2100 + i : 32'h1100 + i);
      end
      if (vecs[i].o0wr) chk($sformatf("v%0d_out0_din", i), ifc.ch0_out_din, 32'hC000 + i);
      if (vecs[i].o1wr) chk($sformatf("v%0d_out1_din", i), ifc.ch1_out_din, 32'hC000 + i);
      tick();
    end

    // Single channel: four back-to-back ch0 issues, all results back to ch0
    do_reset();
    avail(1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #2; if (ifc.ch0_y_rd_en && !ifc.ch1_y_rd_en) cnt++;
      tick();
    end
    chk("single_issues", cnt, 4);
    chk("single_outstanding", outstanding, 4);
    drain("single", n0, n1);
    chk("single_ch0_results", n0, 4);
    chk("single_ch1_results", n1, 0);

    // Fairness: alternating grants, results return in the same alternation
    do_reset();
    avail(1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      #2;
      if (ifc.ch0_y_rd_en !== (i % 2 == 0) || ifc.ch1_y_rd_en !== (i % 2 == 1)) bad++;
      tick();
    end
    chk("fair_grant_errors", bad, 0);
    chk("fair_outstanding", outstanding, 16);
    avail(1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      ifc.core_out_empty = 0;
      #2;
      if (ifc.ch0_out_wr_en !== (i % 2 == 0) || ifc.ch1_out_wr_en !== (i % 2 == 1)) bad++;
      tick();
    end
    ifc.core_out_empty = 1;
    chk("fair_retire_order_errors", bad, 0);
    chk("fair_drained", outstanding, 0);

    // Tag cap: at most 16 pairs in flight; then one issue per retire
    do_reset();
    avail(1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      #2; if (ifc.ch0_y_rd_en) cnt++;
      tick();
    end
    chk("cap_issues", cnt, 16);
    chk("cap_outstanding", outstanding, 16);
    chk("cap_busy", busy, 1);
    ifc.core_out_empty = 0;
    #2;
    chk("cap_no_issue_at_full", ifc.ch0_y_rd_en, 0);
    chk("cap_retire_at_full", ifc.core_out_rd_en, 1);
    tick();
    chk("cap_after_retire", outstanding, 15);
    #2;
    chk("cap_issue_after_retire", ifc.ch0_y_rd_en, 1);
    chk("cap_retire_same_cycle", ifc.core_out_rd_en, 1);
    tick();
    chk("cap_steady", outstanding, 15);
    ifc.core_out_empty = 1;
    #2;
    chk("cap_refill_issue", ifc.ch0_y_rd_en, 1);
    tick();
    chk("cap_refilled", outstanding, 16);
    drain("cap", n0, n1);
    chk("cap_ch0_results", n0, 16);

    // Output backpressure: ch1 at head blocks a queued ch0 result
    do_reset();
    avail(1'b0, 1'b1);
    #2; chk("bp_issue_ch1", ifc.ch1_y_rd_en, 1);
    tick();
    avail(1'b1, 1'b0);
    #2; chk("bp_issue_ch0", ifc.ch0_y_rd_en, 1);
    tick();
    avail(1'b0, 1'b0);
    ifc.core_out_empty = 0;
    ifc.ch1_out_full = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #2; if (ifc.core_out_rd_en || ifc.ch0_out_wr_en || ifc.ch1_out_wr_en) bad++;
      tick();
    end
    chk("bp_stall_violations", bad, 0);
    chk("bp_outstanding_held", outstanding, 2);
    ifc.ch1_out_full = 0;
    #2;
    chk("bp_release_ch1_wr", ifc.ch1_out_wr_en, 1);
    chk("bp_release_ch0_wr", ifc.ch0_out_wr_en, 0);
    chk("bp_release_core_rd", ifc.core_out_rd_en, 1);
    tick();
    #2;
    chk("bp_then_ch0_wr", ifc.ch0_out_wr_en, 1);
    chk("bp_then_ch1_wr", ifc.ch1_out_wr_en, 0);
    tick();
    ifc.core_out_empty = 1;
    chk("bp_drained", outstanding, 0);

    // Simultaneous issue and retire keep the count flat
    do_reset();
    avail(1'b1, 1'b0);
    tick(); tick(); tick();
    chk("sim_fill", outstanding, 3);
    ifc.core_out_empty = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      #2; if (!(ifc.ch0_y_rd_en && ifc.core_out_rd_en)) bad++;
      tick();
      if (outstanding != 3) bad++;
    end
    chk("sim_flat_errors", bad, 0);
    ifc.core_out_empty = 1;
    drain("sim", n0, n1);

    // Reset mid-stream
    do_reset();
    avail(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("rst_fill", outstanding, 5);
    reset = 1'b1;
    ifc.core_out_empty = 0;
    #2;
    chk("rst_enables_off", {ifc.ch0_y_rd_en, ifc.ch0_x_rd_en, ifc.core_y_wr_en,
                            ifc.core_out_rd_en, ifc.ch0_out_wr_en}, 0);
    tick();
    reset = 1'b0;
    ifc.core_out_empty = 1;
    avail(1'b1, 1'b1);
    #2;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tie_ch0", ifc.ch0_y_rd_en, 1);
    chk("rst_tie_not_ch1", ifc.ch1_y_rd_en, 0);
    tick();
    drain("rst", n0, n1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qarctan_channel_arbiter.md
Name: qarctan_channel_arbiter

Overview:
- Shares one qarctan_two_inputs core between two demodulation channels (ch0, ch1), each feeding Y/X sample pairs through FWFT FIFOs.
- Grants ch0 or ch1 round-robin and moves one Y/X pair per cycle into the core's input FIFOs.
- Records the granted channel in an in-order tag queue, then steers each core result to the matching channel's output FIFO.

Parameters:
- DATA_WIDTH, 32, width of Y, X and result words.
- MAX_OUTSTANDING, 16, tag queue depth: maximum pairs issued to the core but not yet retired (power of 2).
- CNT_WIDTH, 5, width of the outstanding count (clog2(MAX_OUTSTANDING)+1).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ch0_y_rd_en / ch1_y_rd_en  out  1  pop channel Y FIFO.
- ch0_y_empty / ch1_y_empty  in  1  channel Y FIFO empty.
- ch0_y_dout / ch1_y_dout  in  DATA_WIDTH  channel Y head word (FWFT).
- ch0_x_rd_en / ch1_x_rd_en  out  1  pop channel X FIFO.
- ch0_x_empty / ch1_x_empty  in  1  channel X FIFO empty.
- ch0_x_dout / ch1_x_dout  in  DATA_WIDTH  channel X head word.
- core_y_wr_en, core_x_wr_en  out  1  push into core input FIFOs.
- core_y_full, core_x_full  in  1  core input FIFOs full.
- core_y_din, core_x_din  out  DATA_WIDTH  data muxed from the granted channel.
- core_out_rd_en  out  1  pop core result FIFO.
- core_out_empty  in  1  core result FIFO empty.
- core_out_dout  in  DATA_WIDTH  core result head word.
- ch0_out_wr_en / ch1_out_wr_en  out  1  push result to channel output FIFO.
- ch0_out_full / ch1_out_full  in  1  channel output FIFO full.
- ch0_out_din / ch1_out_din  out  DATA_WIDTH  result word (both carry core_out_dout).
- outstanding  out  CNT_WIDTH  count of issued, unretired pairs.
- busy  out  1  outstanding != 0.

Behaviour:
- Reset sets outstanding=0, tag queue empty (wr_ptr=rd_ptr=0) and last_grant=1, so ch0 wins the first tie. Reset mid-operation discards all tags; results already in core FIFOs are not flushed (the system resets the core and FIFOs together).
- All rd_en/wr_en outputs are combinational from current state and inputs; they are 0 while reset=1.
- Eligibility: chN is eligible when !chN_y_empty && !chN_x_empty && !core_y_full && !core_x_full && outstanding < MAX_OUTSTANDING.
- Issue (one per cycle):
  - Only one channel eligible: grant it.
  - Both eligible: grant the channel != last_grant.
  - On grant, assert chN_y_rd_en, chN_x_rd_en, core_y_wr_en and core_x_wr_en in the same cycle; core_y_din=chN_y_dout and core_x_din=chN_x_dout.
  - Push tag N at wr_ptr, and update last_grant=N at the clock edge.
  - A channel never has only its Y or only its X FIFO popped.
- Retire:
  - Condition: !core_out_empty && tag queue not empty && !chT_out_full, where T is the tag at rd_ptr.
  - On retire, assert core_out_rd_en and chT_out_wr_en in the same cycle, then advance rd_ptr.
  - Head-of-line: if chT_out_full, retire stalls even when the other channel's output FIFO has room. Results are never reordered.
- Issue and retire are independent and may occur in the same cycle. outstanding gets +1 on issue only, -1 on retire only, unchanged on both.
- Pointers wrap modulo MAX_OUTSTANDING. Queue full means outstanding==MAX_OUTSTANDING; empty means outstanding==0.
- core_out_empty==0 with an empty tag queue is an error: the block does not pop, and a simulation assertion fires.
- Latency: issue happens in the same cycle as eligibility. Retire happens in the same cycle core_out_empty deasserts, given the output FIFO has room.

Test Plan:
- Single channel: ch0 gets 4 pairs (Y=1000,X=1000 etc.), ch1 idle → 4 back-to-back issues with tags 0,0,0,0; ch0_out receives 4 results equal to qarctan golden values; ch1_out_wr_en never asserts; outstanding returns to 0.
- Fairness: ch0 and ch1 both hold 8 pairs, core never full → grant sequence 0,1,0,1,…, 16 issues in 16 cycles; each channel output matches its golden file in order.
- Tag cap: hold core_out_empty=1, feed 20 pairs → exactly 16 issues, outstanding=16, no further rd_en until the first retire, then one issue per retire.
- Output backpressure: tag head=ch1 with ch1_out_full=1 for 10 cycles, ch0 result queued behind it → no core_out_rd_en during those cycles; after release, ch1 then ch0 results are written in order.
- Simultaneous issue/retire: steady stream with outstanding=3 → outstanding stays 3 across cycles where both occur.
- Reset mid-stream: assert reset with outstanding=5 → next cycle outstanding=0, busy=0, all enables 0; ch0 wins the first post-reset tie.
